// File: rtl/echo_pkg.sv
// Shared types and arithmetic helpers for the multi-channel echo engine.
package echo_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_TAP   = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  localparam logic [3:0] FB_OFF = 4'd15;

  // Adds two sign-extended operands and clamps the result to the signed range of a w-bit sample.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = $signed({a[31], a}) + $signed({b[31], b});
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM; one-cycle read latency, contents are not reset.
module echo_ram
  import echo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 8192,
  parameter int AW    = 13
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_mc.sv
// Time-shared delay-echo engine: one datapath serves NCH channels, each with its own
// delay line in a shared RAM, moving samples from input fifos to output fifos.
module echo_mc
  import echo_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 2,
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_dout,
  input  logic [NCH-1:0]       in_empty,
  output logic [NCH-1:0]       in_rd,
  output logic [WIDTH-1:0]     out_din,
  output logic [NCH-1:0]       out_wr,
  input  logic [NCH-1:0]       out_full,
  input  logic [AW-1:0]        delay_len,
  input  logic [3:0]           fb_shift,
  input  logic [NCH-1:0]       effect_en,
  output logic                 busy_clear
);

  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RAW   = CW + AW;
  localparam int WORDS = NCH * DEPTH;
  localparam logic [RAW-1:0] CLR_LAST = RAW'(WORDS - 1);
  localparam logic [CW-1:0]  CH_LAST  = CW'(NCH - 1);

  state_e                  state_q, state_d;
  logic [RAW-1:0]          clr_q, clr_d;
  logic [AW-1:0]           wp_q [NCH];
  logic                    wp_inc_s;
  logic [CW-1:0]           rr_q, rr_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic [AW-1:0]           dl_q, dl_d;
  logic [3:0]              fb_q, fb_d;
  logic                    en_q, en_d;
  logic [NCH-1:0]          in_rd_q, in_rd_d;
  logic [NCH-1:0]          out_wr_q, out_wr_d;
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic                    busy_q, busy_d;

  logic [NCH-1:0]          elig_s;
  logic                    found_s;
  logic [CW-1:0]           sel_s;

  logic                    ram_we_s;
  logic [RAW-1:0]          ram_addr_s;
  logic [WIDTH-1:0]        ram_wdata_s;
  logic signed [WIDTH-1:0] ram_rdata_s;

  echo_ram #(
    .WIDTH (WIDTH),
    .WORDS (WORDS),
    .AW    (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Round-robin pick: walk downward from the farthest offset so the lowest offset from rr_q wins.
  always_comb begin
    elig_s  = ~in_empty & ~out_full;
    found_s = |elig_s;
    sel_s   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      sel_s = elig_s[(int'(rr_q) + k) % NCH] ? CW'((int'(rr_q) + k) % NCH) : sel_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    rr_d        = rr_q;
    ch_d        = ch_q;
    x_d         = x_q;
    y_d         = y_q;
    dl_d        = dl_q;
    fb_d        = fb_q;
    en_d        = en_q;
    in_rd_d     = '0;
    out_wr_d    = '0;
    dout_d      = dout_q;
    wp_inc_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = '0;
    ram_wdata_s = '0;
    case (state_q)
      ST_CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_q;
        if (clr_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_d = clr_q + RAW'(1);
        end
      end
      ST_IDLE: begin
        if (found_s) begin
          in_rd_d[sel_s] = 1'b1;
          ch_d           = sel_s;
          x_d            = in_dout[sel_s*WIDTH +: WIDTH];
          dl_d           = delay_len;
          fb_d           = fb_shift;
          en_d           = effect_en[sel_s];
          state_d        = ST_TAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAP: begin
        // Subtraction stays AW bits wide, so the tap wraps inside the channel's own line.
        ram_addr_s = {ch_q, wp_q[ch_q] - dl_q};
        state_d    = ST_CALC;
      end
      ST_CALC: begin
        if (!en_q || (fb_q == FB_OFF)) begin
          y_d = x_q;
        end else begin
          y_d = WIDTH'(sat_add(32'(x_q), 32'(ram_rdata_s >>> fb_q), WIDTH));
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ram_we_s         = 1'b1;
        ram_addr_s       = {ch_q, wp_q[ch_q]};
        ram_wdata_s      = y_q;
        out_wr_d[ch_q]   = 1'b1;
        dout_d           = y_q;
        wp_inc_s         = 1'b1;
        rr_d             = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
        clr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_CLEAR;
      clr_q    <= '0;
      rr_q     <= '0;
      ch_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dl_q     <= '0;
      fb_q     <= '0;
      en_q     <= 1'b0;
      in_rd_q  <= '0;
      out_wr_q <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        wp_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      rr_q     <= rr_d;
      ch_q     <= ch_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dl_q     <= dl_d;
      fb_q     <= fb_d;
      en_q     <= en_d;
      in_rd_q  <= in_rd_d;
      out_wr_q <= out_wr_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      for (int c = 0; c < NCH; c++) begin
        if (wp_inc_s && (ch_q == CW'(c))) begin
          wp_q[c] <= wp_q[c] + AW'(1);
        end
      end
    end
  end

  assign in_rd      = in_rd_q;
  assign out_wr     = out_wr_q;
  assign out_din    = dout_q;
  assign busy_clear = busy_q;

endmodule

// File: tb/tb_echo_mc.sv
// Scoreboard bench for echo_mc: models the input/output fifos and checks each scenario in turn.
module tb_echo_mc;

  localparam int W     = 16;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH*W-1:0]   in_dout;
  logic [NCH-1:0]     in_empty;
  logic [NCH-1:0]     in_rd;
  logic [W-1:0]       out_din;
  logic [NCH-1:0]     out_wr;
  logic [NCH-1:0]     out_full;
  logic [AW-1:0]      delay_len;
  logic [3:0]         fb_shift;
  logic [NCH-1:0]     effect_en;
  logic               busy_clear;

  logic signed [W-1:0] in_q  [NCH][$];
  logic signed [W-1:0] exp_q [NCH][$];
  logic signed [W-1:0] got_q [NCH][$];
  int n_cmp = 0;
  int n_bad = 0;
  int proto_err = 0;
  int wr_cnt [NCH];

  always #5 clk = ~clk;

  echo_mc #(.WIDTH(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd      (in_rd),
    .out_din    (out_din),
    .out_wr     (out_wr),
    .out_full   (out_full),
    .delay_len  (delay_len),
    .fb_shift   (fb_shift),
    .effect_en  (effect_en),
    .busy_clear (busy_clear)
  );

  // Fifo side: pop inputs on in_rd, capture writes, track strobe protocol violations.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        if (in_rd[c] && in_q[c].size() > 0) void'(in_q[c].pop_front());
        if (out_wr[c]) begin
          got_q[c].push_back(out_din);
          wr_cnt[c]++;
        end
      end
      if ($countones(in_rd) > 1 || $countones(out_wr) > 1 || (in_rd != '0 && out_wr != '0))
        proto_err++;
    end
  end

  always @(negedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      in_empty[c]      = (in_q[c].size() == 0);
      in_dout[c*W +: W] = (in_q[c].size() > 0) ? in_q[c][0] : 16'sd0;
    end
  end

  task automatic clear_queues;
    for (int c = 0; c < NCH; c++) begin
      in_q[c].delete();
      exp_q[c].delete();
      got_q[c].delete();
      wr_cnt[c] = 0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    clear_queues();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 300 && busy_clear !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic wait_got(input int c, input int n);
    for (int i = 0; i < 2000 && got_q[c].size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    int cnt;
    int bad;
    reset = 1'b0;
    clear_queues();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_rd !== 2'b00 || out_wr !== 2'b00) begin
      n_bad++; $display("FAIL reset_strobes: in_rd=%b out_wr=%b, want 00/00", in_rd, out_wr);
    end
    n_cmp++;
    if (out_din !== 16'd0) begin
      n_bad++; $display("FAIL reset_out_din: got %0d, want 0", out_din);
    end
    n_cmp++;
    if (busy_clear !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy: got %b, want 1", busy_clear);
    end
    reset = 1'b1;
    cnt = 0;
    bad = 0;
    while (busy_clear === 1'b1 && cnt < 200) begin
      cnt++;
      if (in_rd !== 2'b00) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_bad++; $display("FAIL clear_cycles: got %0d, want 32", cnt);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL clear_no_rd: got %0d in_rd cycles, want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < NCH*DEPTH; i++) if (dut.u_ram.mem[i] !== 16'd0) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL clear_ram: got %0d nonzero words, want 0", bad);
    end
  endtask

  task automatic test_impulse;
    logic signed [W-1:0] e, g;
    do_reset();
    delay_len = 4'd4; fb_shift = 4'd1; effect_en = 2'b11; out_full = 2'b00;
    for (int k = 0; k < 13; k++) begin
      in_q[0].push_back((k == 0) ? 16'sd16384 : 16'sd0);
      exp_q[0].push_back((k % 4 == 0) ? 16'(16384 >>> (k / 4)) : 16'sd0);
    end
    wait_got(0, 13);
    n_cmp++;
    if (got_q[0].size() != 13) begin
      n_bad++; $display("FAIL impulse_count: got %0d, want 13", got_q[0].size());
    end
    for (int k = 0; exp_q[0].size() > 0 && got_q[0].size() > 0; k++) begin
      e = exp_q[0].pop_front(); g = got_q[0].pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++; $display("FAIL impulse[%0d]: got %0d, want %0d", k, g, e);
      end
    end
  endtask

  task automatic test_saturation;
    logic signed [W-1:0] e, g;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      delay_len = 4'd1; fb_shift = 4'd0; effect_en = 2'b11; out_full = 2'b00;
      for (int k = 0; k < 4; k++) begin
        in_q[0].push_back(pass == 0 ? 16'sd30000 : -16'sd30000);
        if (k == 0) exp_q[0].push_back(pass == 0 ? 16'sd30000 : -16'sd30000);
        else        exp_q[0].push_back(pass == 0 ? 16'sd32767 : -16'sd32768);
      end
      wait_got(0, 4);
      n_cmp++;
      if (got_q[0].size() != 4) begin
        n_bad++; $display("FAIL sat_count[%0d]: got %0d, want 4", pass, got_q[0].size());
      end
      for (int k = 0; exp_q[0].size() > 0 && got_q[0].size() > 0; k++) begin
        e = exp_q[0].pop_front(); g = got_q[0].pop_front();
        n_cmp++;
        if (g !== e) begin
          n_bad++; $display("FAIL sat[%0d][%0d]: got %0d, want %0d", pass, k, g, e);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    logic signed [W-1:0] e, g;
    do_reset();
    delay_len = 4'd4; fb_shift = 4'd15; effect_en = 2'b11; out_full = 2'b10;
    proto_err = 0;
    for (int k = 0; k < 3; k++) begin
      in_q[0].push_back(16'(10 + k)); exp_q[0].push_back(16'(10 + k));
      in_q[1].push_back(16'(20 + k)); exp_q[1].push_back(16'(20 + k));
    end
    wait_got(0, 3);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (wr_cnt[1] !== 0) begin
      n_bad++; $display("FAIL bp_blocked: got %0d ch1 writes, want 0", wr_cnt[1]);
    end
    out_full = 2'b00;
    wait_got(1, 3);
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (got_q[c].size() != 3) begin
        n_bad++; $display("FAIL bp_count[%0d]: got %0d, want 3", c, got_q[c].size());
      end
      for (int k = 0; exp_q[c].size() > 0 && got_q[c].size() > 0; k++) begin
        e = exp_q[c].pop_front(); g = got_q[c].pop_front();
        n_cmp++;
        if (g !== e) begin
          n_bad++; $display("FAIL bp[%0d][%0d]: got %0d, want %0d", c, k, g, e);
        end
      end
    end
    n_cmp++;
    if (proto_err !== 0) begin
      n_bad++; $display("FAIL strobe_protocol: got %0d violations, want 0", proto_err);
    end
  endtask

  task automatic test_bypass;
    logic signed [W-1:0] e, g;
    logic signed [W-1:0] xin [10];
    logic signed [W-1:0] xout [10];
    xin  = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd2000, 16'sd3000,
             16'sd0, 16'sd0, 16'sd0, 16'sd0};
    xout = '{16'sd1000, 16'sd0, 16'sd500, 16'sd0, 16'sd2000, 16'sd3000,
             16'sd1000, 16'sd1500, 16'sd500, 16'sd750};
    do_reset();
    delay_len = 4'd2; fb_shift = 4'd1; effect_en = 2'b11; out_full = 2'b00;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin wait_got(0, 4); effect_en = 2'b10; end
      if (k == 6) begin wait_got(0, 6); effect_en = 2'b11; end
      in_q[0].push_back(xin[k]);
      exp_q[0].push_back(xout[k]);
    end
    wait_got(0, 10);
    n_cmp++;
    if (got_q[0].size() != 10) begin
      n_bad++; $display("FAIL bypass_count: got %0d, want 10", got_q[0].size());
    end
    for (int k = 0; exp_q[0].size() > 0 && got_q[0].size() > 0; k++) begin
      e = exp_q[0].pop_front(); g = got_q[0].pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++; $display("FAIL bypass[%0d]: got %0d, want %0d", k, g, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    int wr_seen;
    do_reset();
    delay_len = 4'd3; fb_shift = 4'd15; effect_en = 2'b11; out_full = 2'b00;
    in_q[0].push_back(16'sd555);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (in_rd[0] === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen !== 1) begin
      n_bad++; $display("FAIL mid_pop: got %0d, want 1", seen);
    end
    @(negedge clk);
    reset = 1'b0;
    wr_seen = 0;
    repeat (6) begin
      #1;
      if (out_wr !== 2'b00) wr_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (wr_seen !== 0 || busy_clear !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset: got wr=%0d busy=%b, want 0/1", wr_seen, busy_clear);
    end
    clear_queues();
    reset = 1'b1;
    for (int i = 0; i < 300 && busy_clear !== 1'b0; i++) @(negedge clk);
    in_q[0].push_back(16'sd777);
    exp_q[0].push_back(16'sd777);
    wait_got(0, 1);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got_q[0].size() != 1) begin
      n_bad++; $display("FAIL mid_count: got %0d, want 1", got_q[0].size());
    end else if (got_q[0][0] !== exp_q[0][0]) begin
      n_bad++; $display("FAIL mid_fresh: got %0d, want %0d", got_q[0][0], exp_q[0][0]);
    end
  endtask

  initial begin
    reset     = 1'b0;
    out_full  = 2'b00;
    delay_len = 4'd0;
    fb_shift  = 4'd15;
    effect_en = 2'b00;
    test_reset();
    test_impulse();
    test_saturation();
    test_back_pressure();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
